// File: rtl/regfile_issue.sv
// regfile_issue: operand-issue and writeback stage of the single-issue core.
//
// Holds the architectural register file (x0 reads as zero and is never written)
// and a single EX register that feeds the external combinational ALU. Decoded
// instructions enter through a valid/ready handshake. The ALU result commits
// back to the destination register when downstream asserts ex_ready_i. A result
// committing in the same cycle as a capture is forwarded, so dependent
// back-to-back instructions never stall.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_*                 decoded instruction handshake and fields
//   ex_valid_o            EX stage occupied
//   alu_op_o, src*_o      registered operands to the ALU
//   alu_result_i/zero_i   combinational ALU outputs
//   ex_ready_i            EX instruction may commit this cycle
//   wb_*                  one-cycle writeback report per commit
//   commit_cnt_o          free-running commit counter (wraps)
//   dbg_addr_i/data_o     combinational debug read port
module regfile_issue #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [3:0]        req_op_i,
    input  logic [ADDR_W-1:0] req_rs1_i,
    input  logic [ADDR_W-1:0] req_rs2_i,
    input  logic [ADDR_W-1:0] req_rd_i,
    input  logic              req_use_imm_i,
    input  logic [DATA_W-1:0] req_imm_i,

    output logic              ex_valid_o,
    output logic [3:0]        alu_op_o,
    output logic [DATA_W-1:0] src1_o,
    output logic [DATA_W-1:0] src2_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i,
    input  logic              ex_ready_i,

    output logic              wb_valid_o,
    output logic [ADDR_W-1:0] wb_rd_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              wb_zero_o,
    output logic [31:0]       commit_cnt_o,

    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    localparam int unsigned NumRegs = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NumRegs];

    logic              ex_valid_q;
    logic [3:0]        alu_op_q;
    logic [DATA_W-1:0] src1_q;
    logic [DATA_W-1:0] src2_q;
    logic [ADDR_W-1:0] ex_rd_q;

    logic              wb_valid_q;
    logic [ADDR_W-1:0] wb_rd_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              wb_zero_q;
    logic [31:0]       commit_cnt_q;

    logic              commit;
    logic              accept;
    logic [DATA_W-1:0] src1_d;
    logic [DATA_W-1:0] src2_d;

    assign commit      = ex_valid_q && ex_ready_i;
    assign req_ready_o = !ex_valid_q || ex_ready_i;
    assign accept      = req_valid_i && req_ready_o;

    // Operand select: x0 is zero, then the committing result (forwarding),
    // then the register file. Forwarding from rd == 0 must never happen.
    always_comb begin
        src1_d = '0;
        if (req_rs1_i != '0) begin
            if (commit && (ex_rd_q == req_rs1_i)) begin
                src1_d = alu_result_i;
            end else begin
                src1_d = regs_q[req_rs1_i];
            end
        end

        src2_d = '0;
        if (req_use_imm_i) begin
            src2_d = req_imm_i;
        end else if (req_rs2_i != '0) begin
            if (commit && (ex_rd_q == req_rs2_i)) begin
                src2_d = alu_result_i;
            end else begin
                src2_d = regs_q[req_rs2_i];
            end
        end
    end

    assign dbg_data_o = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit && (ex_rd_q != '0)) begin
            regs_q[ex_rd_q] <= alu_result_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_valid_q   <= 1'b0;
            alu_op_q     <= '0;
            src1_q       <= '0;
            src2_q       <= '0;
            ex_rd_q      <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            wb_zero_q    <= 1'b0;
            commit_cnt_q <= '0;
        end else begin
            // Accept takes priority so commit+accept refills EX without a bubble.
            if (accept) begin
                ex_valid_q <= 1'b1;
                alu_op_q   <= req_op_i;
                src1_q     <= src1_d;
                src2_q     <= src2_d;
                ex_rd_q    <= req_rd_i;
            end else if (commit) begin
                ex_valid_q <= 1'b0;
            end

            wb_valid_q <= commit;
            if (commit) begin
                wb_rd_q      <= ex_rd_q;
                wb_data_q    <= alu_result_i;
                wb_zero_q    <= alu_zero_i;
                commit_cnt_q <= commit_cnt_q + 32'd1;
            end
        end
    end

    assign ex_valid_o   = ex_valid_q;
    assign alu_op_o     = alu_op_q;
    assign src1_o       = src1_q;
    assign src2_o       = src2_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_rd_o      = wb_rd_q;
    assign wb_data_o    = wb_data_q;
    assign wb_zero_o    = wb_zero_q;
    assign commit_cnt_o = commit_cnt_q;

endmodule
